// File: rtl/byte_lane_data_mem_if.sv
// byte_lane_data_mem_if: request/response bus of the byte-lane data memory
interface byte_lane_data_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/byte_lane_data_mem.sv
// byte_lane_data_mem: big-endian byte-addressed data memory with sized, sign/zero-extended loads
module byte_lane_data_mem #(
  parameter int    ADDR_WIDTH    = 10,
  parameter int    DATA_WIDTH    = 32,
  parameter string MEM_INIT_FILE = ""
) (
  input logic                 clk,
  input logic                 rst_n,
  byte_lane_data_mem_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [3:0]            nb;
  logic                  err;
  logic                  we;
  logic [DATA_WIDTH-1:0] ld;
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("byte_lane_data_mem: DATA_WIDTH must be 32 or 64");
  end
  // lane i carries the field's byte i counted from the LSB, stored at addr+nb-1-i;
  // the sign lives in the byte at req_addr since it is the most significant one
  always_comb begin
    nb  = 4'd1 << bus.req_size;
    err = (bus.req_size == 2'd3 && DATA_WIDTH == 32) ||
          ((bus.req_addr[2:0] & 3'(nb - 4'd1)) != 3'd0);
    we  = bus.req_valid & bus.req_write & ~err;
    ld  = '0;
    for (int i = 0; i < NB; i++)
      ld[8*i+:8] = i < int'(nb) ? mem[bus.req_addr + ADDR_WIDTH'(int'(nb) - 1 - i)]
                                : {8{~bus.req_unsigned & mem[bus.req_addr][7]}};
  end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < NB; i++)
        if (i < int'(nb)) mem[bus.req_addr + ADDR_WIDTH'(int'(nb) - 1 - i)] <= bus.req_wdata[8*i+:8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= bus.req_valid & (err | ~bus.req_write);
      bus.rsp_err   <= bus.req_valid & err;
      if (bus.req_valid & err) bus.rsp_rdata <= '0;
      else if (bus.req_valid & ~bus.req_write) bus.rsp_rdata <= ld;
    end
endmodule

// File: tb/tb_byte_lane_data_mem.sv
// tb_byte_lane_data_mem: directed checks of 32- and 64-bit data memory instances
module tb_byte_lane_data_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  byte_lane_data_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b32 ();
  byte_lane_data_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) b64 ();
  byte_lane_data_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_INIT_FILE("")) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32));
  byte_lane_data_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .MEM_INIT_FILE("")) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input bit w64, input bit w, input logic [1:0] sz, input bit u,
                    input logic [9:0] a, input logic [63:0] wd);
    @(negedge clk);
    if (w64) begin
      b64.req_valid = 1'b1; b64.req_write = w; b64.req_size = sz;
      b64.req_unsigned = u; b64.req_addr = a; b64.req_wdata = wd;
    end else begin
      b32.req_valid = 1'b1; b32.req_write = w; b32.req_size = sz;
      b32.req_unsigned = u; b32.req_addr = a; b32.req_wdata = wd[31:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rd(input bit w64);
    return w64 ? b64.rsp_rdata : {32'h0, b32.rsp_rdata};
  endfunction

  task automatic st(input bit w64, input string tag, input logic [1:0] sz,
                    input logic [9:0] a, input logic [63:0] wd);
    op(w64, 1'b1, sz, 1'b0, a, wd);
    chk({tag, "_nov"}, w64 ? b64.rsp_valid : b32.rsp_valid, 64'd0);
  endtask

  task automatic ld(input bit w64, input string tag, input logic [1:0] sz, input bit u,
                    input logic [9:0] a, input logic [63:0] exp);
    op(w64, 1'b0, sz, u, a, 64'd0);
    chk({tag, "_v"}, w64 ? b64.rsp_valid : b32.rsp_valid, 64'd1);
    chk({tag, "_e"}, w64 ? b64.rsp_err : b32.rsp_err, 64'd0);
    chk(tag, rd(w64), exp);
  endtask

  task automatic er(input bit w64, input string tag, input bit w, input logic [1:0] sz,
                    input logic [9:0] a);
    op(w64, w, sz, 1'b0, a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_v"}, w64 ? b64.rsp_valid : b32.rsp_valid, 64'd1);
    chk({tag, "_e"}, w64 ? b64.rsp_err : b32.rsp_err, 64'd1);
    chk(tag, rd(w64), 64'd0);
  endtask

  initial begin
    b32.req_valid = 1'b0; b32.req_write = 1'b0; b32.req_size = 2'd0;
    b32.req_unsigned = 1'b0; b32.req_addr = '0; b32.req_wdata = '0;
    b64.req_valid = 1'b0; b64.req_write = 1'b0; b64.req_size = 2'd0;
    b64.req_unsigned = 1'b0; b64.req_addr = '0; b64.req_wdata = '0;
    #22;
    chk("rst_v", b32.rsp_valid, 64'd0);
    chk("rst_e", b32.rsp_err, 64'd0);
    chk("rst_d", rd(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    st(0, "sw10", 2'd2, 10'h010, 64'hDEAD_BEEF);
    ld(0, "lw10", 2'd2, 1'b0, 10'h010, 64'hDEAD_BEEF);
    ld(0, "lbu10", 2'd0, 1'b1, 10'h010, 64'h0000_00DE);
    ld(0, "lbu11", 2'd0, 1'b1, 10'h011, 64'h0000_00AD);
    ld(0, "lbu12", 2'd0, 1'b1, 10'h012, 64'h0000_00BE);
    ld(0, "lbu13", 2'd0, 1'b1, 10'h013, 64'h0000_00EF);
    ld(0, "lb12", 2'd0, 1'b0, 10'h012, 64'hFFFF_FFBE);
    ld(0, "lh12", 2'd1, 1'b0, 10'h012, 64'hFFFF_BEEF);
    ld(0, "lhu10", 2'd1, 1'b1, 10'h010, 64'h0000_DEAD);
    ld(0, "lh10s", 2'd1, 1'b0, 10'h010, 64'hFFFF_DEAD);
    idle();
    chk("idle_v", b32.rsp_valid, 64'd0);
    chk("idle_hold", rd(0), 64'hFFFF_DEAD);

    st(0, "sb11", 2'd0, 10'h011, 64'h5A);
    ld(0, "lw10b", 2'd2, 1'b0, 10'h010, 64'hDE5A_BEEF);
    er(0, "lw12mis", 1'b0, 2'd2, 10'h012);
    er(0, "sh13mis", 1'b1, 2'd1, 10'h013);
    er(0, "sd32ill", 1'b0, 2'd3, 10'h000);
    er(0, "sw10ill", 1'b1, 2'd3, 10'h010);
    ld(0, "lw10c", 2'd2, 1'b0, 10'h010, 64'hDE5A_BEEF);

    for (int k = 0; k < 5; k++) st(0, "swb2b", 2'd2, 10'(32 + 4 * k), 64'(32'h7A0B_0C00 + k));
    for (int k = 0; k < 5; k++) ld(0, $sformatf("b2b%0d", k), 2'd2, 1'b0, 10'(32 + 4 * k), 64'(32'h7A0B_0C00 + k));
    ld(0, "lh22", 2'd1, 1'b0, 10'h022, 64'h0000_0C00);

    ld(0, "pre_rst", 2'd2, 1'b0, 10'h024, 64'h7A0B_0C01);
    @(negedge clk);
    b32.req_valid = 1'b1; b32.req_write = 1'b0; b32.req_size = 2'd2; b32.req_addr = 10'h010;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", b32.rsp_valid, 64'd0);
    chk("arst_e", b32.rsp_err, 64'd0);
    chk("arst_d", rd(0), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_v", b32.rsp_valid, 64'd0);
    chk("arst_hold_d", rd(0), 64'd0);
    @(negedge clk);
    b32.req_valid = 1'b0;
    rst_n = 1'b1;
    ld(0, "post_rst", 2'd2, 1'b0, 10'h010, 64'hDE5A_BEEF);

    st(1, "sd08", 2'd3, 10'h008, 64'h0123_4567_89AB_CDEF);
    ld(1, "lwu0c", 2'd2, 1'b1, 10'h00C, 64'h0000_0000_89AB_CDEF);
    ld(1, "lw0c", 2'd2, 1'b0, 10'h00C, 64'hFFFF_FFFF_89AB_CDEF);
    ld(1, "ld08", 2'd3, 1'b0, 10'h008, 64'h0123_4567_89AB_CDEF);
    ld(1, "lw08", 2'd2, 1'b0, 10'h008, 64'h0000_0000_0123_4567);
    ld(1, "lbu0f", 2'd0, 1'b1, 10'h00F, 64'h0000_0000_0000_00EF);
    ld(1, "lh0e", 2'd1, 1'b0, 10'h00E, 64'hFFFF_FFFF_FFFF_CDEF);
    er(1, "sd0cmis", 1'b1, 2'd3, 10'h00C);
    ld(1, "ld08b", 2'd3, 1'b1, 10'h008, 64'h0123_4567_89AB_CDEF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
